comp_pointer_arbiter: RTL and testbench

//  Sequencer in front of the comparator pointer register file (per-core start/end/head/tail pointers per task).

---
 rtl/comp_pointer_arbiter_if.sv | 53 +++++
 rtl/comp_pointer_arbiter.sv | 132 +++++++++++++
 tb/tb_comp_pointer_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/comp_pointer_arbiter_if.sv
// Request/ack and register-file command bundle for the comparator pointer arbiter.
// The arbiter uses the slave modport; requesters and the register file see the master side.
interface comp_pointer_arbiter_if #(
  parameter int KEY_WIDTH  = 4,
  parameter int ADDR_WIDTH = 10
);
  logic                  csr_start_req;
  logic                  csr_end_req;
  logic [1:0]            csr_core_id;
  logic [KEY_WIDTH-1:0]  csr_task_id;
  logic [ADDR_WIDTH-1:0] csr_data;
  logic                  csr_ack;

  logic                  fp_inc_req;
  logic [1:0]            fp_core_id;
  logic [KEY_WIDTH-1:0]  fp_task_id;
  logic                  fp_ack;

  logic                  cmp_inc_req;
  logic                  cmp_rst_req;
  logic [KEY_WIDTH-1:0]  cmp_task_id;
  logic                  cmp_ack;

  logic [2:0]            rf_op;
  logic [1:0]            rf_core_id;
  logic [KEY_WIDTH-1:0]  rf_task_id;
  logic [ADDR_WIDTH-1:0] rf_data;
  logic                  rf_done;

  logic                  busy;
  logic                  timeout_err;
  logic                  err_clear;

  modport slave (
    input  csr_start_req, csr_end_req, csr_core_id, csr_task_id, csr_data,
    input  fp_inc_req, fp_core_id, fp_task_id,
    input  cmp_inc_req, cmp_rst_req, cmp_task_id,
    input  rf_done, err_clear,
    output csr_ack, fp_ack, cmp_ack,
    output rf_op, rf_core_id, rf_task_id, rf_data,
    output busy, timeout_err
  );

  modport master (
    output csr_start_req, csr_end_req, csr_core_id, csr_task_id, csr_data,
    output fp_inc_req, fp_core_id, fp_task_id,
    output cmp_inc_req, cmp_rst_req, cmp_task_id,
    output rf_done, err_clear,
    input  csr_ack, fp_ack, cmp_ack,
    input  rf_op, rf_core_id, rf_task_id, rf_data,
    input  busy, timeout_err
  );
endinterface

// File: rtl/comp_pointer_arbiter.sv
// Round-robin sequencer for the comparator pointer register file: one op in flight,
// completion wait with watchdog, single-cycle ack to the granted requester.
module comp_pointer_arbiter #(
  parameter int KEY_WIDTH  = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  comp_pointer_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;
  typedef enum logic [1:0] {REQ_CSR, REQ_FP, REQ_CMP} req_e;
  typedef enum logic [2:0] {
    OP_NONE       = 3'd0,
    OP_START_WR   = 3'd1,
    OP_END_WR     = 3'd2,
    OP_INC_HEAD   = 3'd3,
    OP_INC_TAIL   = 3'd4,
    OP_RESET_TASK = 3'd5
  } op_e;

  state_e                state_q, state_d;
  req_e                  rr_last_q, grant_q, win;
  op_e                   op_q, win_op;
  logic                  has_csr, has_fp, has_cmp, win_vld;
  logic [1:0]            win_core, core_q;
  logic [KEY_WIDTH-1:0]  win_task, task_q;
  logic [ADDR_WIDTH-1:0] win_data, data_q;
  logic [CNT_W-1:0]      wd_cnt_q;
  logic                  abort;
  logic                  timeout_err_q;

  assign has_csr = bus.csr_start_req | bus.csr_end_req;
  assign has_fp  = bus.fp_inc_req;
  assign has_cmp = bus.cmp_inc_req | bus.cmp_rst_req;
  assign win_vld = has_csr | has_fp | has_cmp;

  // Search starts at the requester after the last one served, wrapping CSR -> FPRINT -> COMP.
  always_comb begin
    win = REQ_CSR;
    case (rr_last_q)
      REQ_CSR: win = has_fp  ? REQ_FP  : (has_cmp ? REQ_CMP : REQ_CSR);
      REQ_FP:  win = has_cmp ? REQ_CMP : (has_csr ? REQ_CSR : REQ_FP);
      default: win = has_csr ? REQ_CSR : (has_fp  ? REQ_FP  : REQ_CMP);
    endcase
  end

  always_comb begin
    win_op   = OP_NONE;
    win_core = '0;
    win_task = '0;
    win_data = '0;
    case (win)
      REQ_CSR: begin
        win_op   = bus.csr_start_req ? OP_START_WR : OP_END_WR;
        win_core = bus.csr_core_id;
        win_task = bus.csr_task_id;
        win_data = bus.csr_data;
      end
      REQ_FP: begin
        win_op   = OP_INC_HEAD;
        win_core = bus.fp_core_id;
        win_task = bus.fp_task_id;
      end
      default: begin
        win_op   = bus.cmp_rst_req ? OP_RESET_TASK : OP_INC_TAIL;
        win_task = bus.cmp_task_id;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    case (state_q)
      IDLE:  if (win_vld) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (bus.rf_done) begin
          state_d = ACK;
        end else if (wd_cnt_q == CNT_W'(TIMEOUT)) begin
          abort   = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_last_q     <= REQ_CMP;
      grant_q       <= REQ_CSR;
      op_q          <= OP_NONE;
      core_q        <= '0;
      task_q        <= '0;
      data_q        <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && win_vld) begin
        grant_q <= win;
        op_q    <= win_op;
        core_q  <= win_core;
        task_q  <= win_task;
        data_q  <= win_data;
      end
      wd_cnt_q <= (state_q == WAIT) ? wd_cnt_q + 1'b1 : '0;
      if (state_q == ACK) rr_last_q <= grant_q;
      if (abort)              timeout_err_q <= 1'b1;
      else if (bus.err_clear) timeout_err_q <= 1'b0;
    end
  end

  assign bus.rf_op       = (state_q == ISSUE) ? op_q : OP_NONE;
  assign bus.rf_core_id  = core_q;
  assign bus.rf_task_id  = task_q;
  assign bus.rf_data     = data_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = timeout_err_q;
  assign bus.csr_ack     = (state_q == ACK) && (grant_q == REQ_CSR);
  assign bus.fp_ack      = (state_q == ACK) && (grant_q == REQ_FP);
  assign bus.cmp_ack     = (state_q == ACK) && (grant_q == REQ_CMP);

endmodule

// File: tb/tb_comp_pointer_arbiter.sv
// Bench for comp_pointer_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbitration and completion timing.
module tb_comp_pointer_arbiter;

  localparam int KW = 4;
  localparam int AW = 10;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  comp_pointer_arbiter_if #(.KEY_WIDTH(KW), .ADDR_WIDTH(AW)) bus ();

  comp_pointer_arbiter #(.KEY_WIDTH(KW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // pending request levels held by each requester
  bit p_cs, p_ce, p_fp, p_ci, p_cr;
  int rr_last;
  bit exp_err;
  logic [1:0]    m_csr_core, m_fp_core;
  logic [KW-1:0] m_csr_task, m_fp_task, m_cmp_task;
  logic [AW-1:0] m_csr_data;
  logic [1:0]    exp_core;
  logic [KW-1:0] exp_task;
  logic [AW-1:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit has(input int r);
    if (r == 0) return p_cs | p_ce;
    if (r == 1) return p_fp;
    return p_ci | p_cr;
  endfunction

  task automatic drive();
    bus.csr_start_req = p_cs;
    bus.csr_end_req   = p_ce;
    bus.csr_core_id   = m_csr_core;
    bus.csr_task_id   = m_csr_task;
    bus.csr_data      = m_csr_data;
    bus.fp_inc_req    = p_fp;
    bus.fp_core_id    = m_fp_core;
    bus.fp_task_id    = m_fp_task;
    bus.cmp_inc_req   = p_ci;
    bus.cmp_rst_req   = p_cr;
    bus.cmp_task_id   = m_cmp_task;
  endtask

  task automatic step(input bit abort_edge);
    @(posedge clk);
    #1;
    if (abort_edge)         exp_err = 1'b1;
    else if (bus.err_clear) exp_err = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_op"}, bus.rf_op, 0);
    chk({tag, "_acks"}, {bus.csr_ack, bus.fp_ack, bus.cmp_ack}, 0);
    chk({tag, "_err"}, bus.timeout_err, exp_err);
    chk({tag, "_regs"}, {bus.rf_core_id, bus.rf_task_id, bus.rf_data}, {exp_core, exp_task, exp_data});
  endtask

  task automatic model_reset();
    rr_last  = 2;
    exp_err  = 1'b0;
    exp_core = '0;
    exp_task = '0;
    exp_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    chk_idle("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Called in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
  task automatic run_txn(input int d, input bit spur);
    int r;
    int ack_c;
    bit to;
    logic [2:0] eop;
    logic [2:0] ack_vec;
    r = -1;
    for (int k = 1; k <= 3; k++) begin
      int cand;
      cand = (rr_last + k) % 3;
      if (r < 0 && has(cand)) r = cand;
    end
    if (r < 0) begin
      chk("txn_no_request", 1, 0);
      return;
    end
    case (r)
      0: begin
        eop = p_cs ? 3'd1 : 3'd2;
        exp_core = m_csr_core; exp_task = m_csr_task; exp_data = m_csr_data;
      end
      1: begin
        eop = 3'd3;
        exp_core = m_fp_core; exp_task = m_fp_task; exp_data = '0;
      end
      default: begin
        eop = p_cr ? 3'd5 : 3'd4;
        exp_core = '0; exp_task = m_cmp_task; exp_data = '0;
      end
    endcase
    ack_vec = 3'b100 >> r;
    to      = (d > TO);
    ack_c   = 3 + (to ? TO : d);
    bus.rf_done = spur;
    for (int c = 1; c <= ack_c; c++) begin
      step(to && c == ack_c);
      bus.rf_done = (!to && c == 2 + d) || (spur && c == 1);
      chk("rf_op", bus.rf_op, (c == 1) ? eop : 3'd0);
      chk("busy", bus.busy, 1);
      chk("acks", {bus.csr_ack, bus.fp_ack, bus.cmp_ack}, (c == ack_c) ? ack_vec : 3'b000);
      chk("timeout_err", bus.timeout_err, exp_err);
      if (c == 1 || c == ack_c)
        chk("rf_regs", {bus.rf_core_id, bus.rf_task_id, bus.rf_data}, {exp_core, exp_task, exp_data});
    end
    bus.rf_done = 1'b0;
    case (r)
      0:       if (p_cs) p_cs = 1'b0; else p_ce = 1'b0;
      1:       p_fp = 1'b0;
      default: if (p_cr) p_cr = 1'b0; else p_ci = 1'b0;
    endcase
    rr_last = r;
    drive();
    step(1'b0);
    chk_idle("post_ack");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    {p_cs, p_ce, p_fp, p_ci, p_cr} = '0;
    m_csr_core = '0; m_fp_core = '0;
    m_csr_task = '0; m_fp_task = '0; m_cmp_task = '0;
    m_csr_data = '0;
    bus.rf_done   = 1'b0;
    bus.err_clear = 1'b0;
    drive();
    model_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    chk_idle("after_reset");

    // single CSR start write, no contention
    p_cs = 1'b1; m_csr_core = 2'd1; m_csr_task = 4'd3; m_csr_data = 10'h040;
    drive();
    run_txn(0, 1'b0);

    // three requesters held from reset: CSR, FPRINT, COMP
    do_reset();
    p_cs = 1'b1; p_fp = 1'b1; p_ci = 1'b1;
    m_fp_core = 2'd2; m_fp_task = 4'd9; m_cmp_task = 4'd12;
    drive();
    repeat (3) run_txn(1, 1'b0);

    // comparator reset beats increment
    p_cr = 1'b1; p_ci = 1'b1; m_cmp_task = 4'd7;
    drive();
    run_txn(0, 1'b1);
    run_txn(2, 1'b0);

    // watchdog abort, then clear
    p_fp = 1'b1;
    drive();
    run_txn(TO + 5, 1'b0);
    chk("err_set", bus.timeout_err, 1);
    bus.err_clear = 1'b1;
    step(1'b0);
    chk("err_cleared", bus.timeout_err, 0);

    // set wins over a clear held through the abort edge
    p_cs = 1'b1; p_ce = 1'b1; m_csr_data = 10'h3ff;
    drive();
    run_txn(TO + 1, 1'b0);
    bus.err_clear = 1'b0;
    run_txn(TO, 1'b0);

    // reset in the middle of WAIT drops the op
    p_fp = 1'b1;
    drive();
    step(1'b0);
    step(1'b0);
    chk("wait_busy", bus.busy, 1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_idle("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_txn(1, 1'b0);

    // FPRINT held, CSR re-requests every IDLE: grants alternate
    p_fp = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p_cs = 1'b1;
      m_csr_data = AW'($urandom_range(0, 1023));
      p_fp = 1'b1;
      drive();
      run_txn($urandom_range(0, 3), 1'b0);
    end
    p_fp = 1'b0; p_cs = 1'b0;
    drive();
    step(1'b0);
    if (bus.busy) run_txn(0, 1'b0);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      if (!p_cs && $urandom_range(0, 2) == 0) p_cs = 1'b1;
      if (!p_ce && $urandom_range(0, 3) == 0) p_ce = 1'b1;
      if (!(p_cs || p_ce)) begin
        m_csr_core = 2'($urandom_range(0, 3));
        m_csr_task = KW'($urandom_range(0, 15));
        m_csr_data = AW'($urandom_range(0, 1023));
      end
      if (!p_fp) begin
        m_fp_core = 2'($urandom_range(0, 3));
        m_fp_task = KW'($urandom_range(0, 15));
        p_fp = ($urandom_range(0, 2) == 0);
      end
      if (!(p_ci || p_cr)) m_cmp_task = KW'($urandom_range(0, 15));
      if (!p_ci && $urandom_range(0, 3) == 0) p_ci = 1'b1;
      if (!p_cr && $urandom_range(0, 4) == 0) p_cr = 1'b1;
      bus.err_clear = ($urandom_range(0, 3) == 0);
      drive();
      if (p_cs || p_ce || p_fp || p_ci || p_cr) begin
        run_txn($urandom_range(0, TO + 4), $urandom_range(0, 1) == 1);
      end else begin
        bus.rf_done = $urandom_range(0, 1) == 1;
        step(1'b0);
        bus.rf_done = 1'b0;
        chk_idle("rand_idle");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
